// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator for the decode stage.
// Decodes one RV32I/RV64I instruction per cycle into a sign-extended immediate and a
// format code, registers the result behind a 2-entry skid buffer (O = output, K = skid)
// and keeps a saturating count of accepted illegal opcodes.
module imm_gen_pipe #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned TAG_W = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic [TAG_W-1:0] out_tag,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam logic [2:0] FmtR       = 3'd0;
    localparam logic [2:0] FmtI       = 3'd1;
    localparam logic [2:0] FmtS       = 3'd2;
    localparam logic [2:0] FmtB       = 3'd3;
    localparam logic [2:0] FmtU       = 3'd4;
    localparam logic [2:0] FmtJ       = 3'd5;
    localparam logic [2:0] FmtShamt   = 3'd6;
    localparam logic [2:0] FmtIllegal = 3'd7;

    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            sgn;
    logic            is_shift;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] imm_j;
    logic [XLEN-1:0] shamt5;
    logic [XLEN-1:0] shamt6;
    logic [XLEN-1:0] shamt_op;

    logic [XLEN-1:0] dec_imm;
    logic [2:0]      dec_fmt;

    assign opcode   = in_instr[6:0];
    assign funct3   = in_instr[14:12];
    assign sgn      = in_instr[31];
    assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

    assign imm_i  = {{(XLEN-12){sgn}}, in_instr[31:20]};
    assign imm_s  = {{(XLEN-12){sgn}}, in_instr[31:25], in_instr[11:7]};
    assign imm_b  = {{(XLEN-13){sgn}}, in_instr[31], in_instr[7], in_instr[30:25],
                     in_instr[11:8], 1'b0};
    assign imm_u  = {{(XLEN-32){sgn}}, in_instr[31:12], 12'b0};
    assign imm_j  = {{(XLEN-21){sgn}}, in_instr[31], in_instr[19:12], in_instr[20],
                     in_instr[30:21], 1'b0};
    assign shamt5 = {{(XLEN-5){1'b0}}, in_instr[24:20]};
    assign shamt6 = {{(XLEN-6){1'b0}}, in_instr[25:20]};
    // OP-IMM shift amounts are 6 bits wide on RV64, 5 bits on RV32
    assign shamt_op = (XLEN == 64) ? shamt6 : shamt5;

    // Opcode decode into format code and immediate
    always_comb begin
        dec_fmt = FmtIllegal;
        dec_imm = '0;
        case (opcode)
            7'b0010011: begin
                if (is_shift) begin
                    dec_fmt = FmtShamt;
                    dec_imm = shamt_op;
                end else begin
                    dec_fmt = FmtI;
                    dec_imm = imm_i;
                end
            end
            7'b0000011, 7'b1100111: begin
                dec_fmt = FmtI;
                dec_imm = imm_i;
            end
            7'b0011011: begin
                // OP-IMM-32 only exists on RV64
                if (XLEN == 64) begin
                    if (is_shift) begin
                        dec_fmt = FmtShamt;
                        dec_imm = shamt5;
                    end else begin
                        dec_fmt = FmtI;
                        dec_imm = imm_i;
                    end
                end
            end
            7'b0100011: begin
                dec_fmt = FmtS;
                dec_imm = imm_s;
            end
            7'b1100011: begin
                dec_fmt = FmtB;
                dec_imm = imm_b;
            end
            7'b0110111, 7'b0010111: begin
                dec_fmt = FmtU;
                dec_imm = imm_u;
            end
            7'b1101111: begin
                dec_fmt = FmtJ;
                dec_imm = imm_j;
            end
            7'b0110011: begin
                dec_fmt = FmtR;
            end
            7'b0111011: begin
                if (XLEN == 64) begin
                    dec_fmt = FmtR;
                end
            end
            default: begin
                dec_fmt = FmtIllegal;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Skid buffer
    // ------------------------------------------------------------------
    logic             o_valid_q, o_valid_d;
    logic [XLEN-1:0]  o_imm_q,   o_imm_d;
    logic [2:0]       o_fmt_q,   o_fmt_d;
    logic [TAG_W-1:0] o_tag_q,   o_tag_d;
    logic             k_valid_q, k_valid_d;
    logic [XLEN-1:0]  k_imm_q,   k_imm_d;
    logic [2:0]       k_fmt_q,   k_fmt_d;
    logic [TAG_W-1:0] k_tag_q,   k_tag_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;

    logic accept;
    logic drain;

    // in_ready comes straight from a flop, so out_ready never reaches it combinationally
    assign in_ready = ~k_valid_q;
    assign accept   = in_valid & in_ready;
    assign drain    = o_valid_q & out_ready;

    // Next state of O/K: O always holds the older entry, K the younger
    always_comb begin
        o_valid_d = o_valid_q;
        o_imm_d   = o_imm_q;
        o_fmt_d   = o_fmt_q;
        o_tag_d   = o_tag_q;
        k_valid_d = k_valid_q;
        k_imm_d   = k_imm_q;
        k_fmt_d   = k_fmt_q;
        k_tag_d   = k_tag_q;
        if (!o_valid_q || drain) begin
            if (k_valid_q) begin
                // K is pending (in_ready is low, so nothing new is accepted)
                o_valid_d = 1'b1;
                o_imm_d   = k_imm_q;
                o_fmt_d   = k_fmt_q;
                o_tag_d   = k_tag_q;
                k_valid_d = 1'b0;
            end else if (accept) begin
                o_valid_d = 1'b1;
                o_imm_d   = dec_imm;
                o_fmt_d   = dec_fmt;
                o_tag_d   = in_tag;
            end else begin
                o_valid_d = 1'b0;
            end
        end else if (accept) begin
            // O stalled: park the new result in K
            k_valid_d = 1'b1;
            k_imm_d   = dec_imm;
            k_fmt_d   = dec_fmt;
            k_tag_d   = in_tag;
        end
    end

    // Illegal-opcode counter: clear wins over increment, saturates at all-ones
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (accept && (dec_fmt == FmtIllegal) && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            o_valid_q <= 1'b0;
            o_imm_q   <= '0;
            o_fmt_q   <= '0;
            o_tag_q   <= '0;
            k_valid_q <= 1'b0;
            k_imm_q   <= '0;
            k_fmt_q   <= '0;
            k_tag_q   <= '0;
            cnt_q     <= '0;
        end else begin
            o_valid_q <= o_valid_d;
            o_imm_q   <= o_imm_d;
            o_fmt_q   <= o_fmt_d;
            o_tag_q   <= o_tag_d;
            k_valid_q <= k_valid_d;
            k_imm_q   <= k_imm_d;
            k_fmt_q   <= k_fmt_d;
            k_tag_q   <= k_tag_d;
            cnt_q     <= cnt_d;
        end
    end

    assign out_valid   = o_valid_q;
    assign out_imm     = o_imm_q;
    assign out_fmt     = o_fmt_q;
    assign out_tag     = o_tag_q;
    assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: an RV64 instance with a 16-bit counter and an RV32
// instance with a 2-bit counter, sharing clock and reset.
module tb_imm_gen_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // RV64 instance
    logic        a_in_valid = 1'b0;
    logic        a_in_ready;
    logic [31:0] a_in_instr = '0;
    logic [7:0]  a_in_tag   = '0;
    logic        a_out_valid;
    logic        a_out_ready = 1'b1;
    logic [63:0] a_out_imm;
    logic [2:0]  a_out_fmt;
    logic [7:0]  a_out_tag;
    logic        a_cnt_clr = 1'b0;
    logic [15:0] a_cnt;

    // RV32 instance
    logic        b_in_valid = 1'b0;
    logic        b_in_ready;
    logic [31:0] b_in_instr = '0;
    logic [7:0]  b_in_tag   = '0;
    logic        b_out_valid;
    logic        b_out_ready = 1'b1;
    logic [31:0] b_out_imm;
    logic [2:0]  b_out_fmt;
    logic [7:0]  b_out_tag;
    logic        b_cnt_clr = 1'b0;
    logic [1:0]  b_cnt;

    imm_gen_pipe #(.XLEN(64), .TAG_W(8), .CNT_W(16)) u_dut64 (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (a_in_valid),
        .in_ready    (a_in_ready),
        .in_instr    (a_in_instr),
        .in_tag      (a_in_tag),
        .out_valid   (a_out_valid),
        .out_ready   (a_out_ready),
        .out_imm     (a_out_imm),
        .out_fmt     (a_out_fmt),
        .out_tag     (a_out_tag),
        .cnt_clr     (a_cnt_clr),
        .illegal_cnt (a_cnt)
    );

    imm_gen_pipe #(.XLEN(32), .TAG_W(8), .CNT_W(2)) u_dut32 (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (b_in_valid),
        .in_ready    (b_in_ready),
        .in_instr    (b_in_instr),
        .in_tag      (b_in_tag),
        .out_valid   (b_out_valid),
        .out_ready   (b_out_ready),
        .out_imm     (b_out_imm),
        .out_fmt     (b_out_fmt),
        .out_tag     (b_out_tag),
        .cnt_clr     (b_cnt_clr),
        .illegal_cnt (b_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Back-to-back vectors for the RV64 instance
    logic [31:0] vec_instr [4];
    logic [63:0] vec_imm   [4];
    logic [2:0]  vec_fmt   [4];

    initial begin
        vec_instr[0] = 32'hFE112E23; vec_imm[0] = 64'hFFFF_FFFF_FFFF_FFFC; vec_fmt[0] = 3'd2;
        vec_instr[1] = 32'hFE000CE3; vec_imm[1] = 64'hFFFF_FFFF_FFFF_FFF8; vec_fmt[1] = 3'd3;
        vec_instr[2] = 32'h123450B7; vec_imm[2] = 64'h0000_0000_1234_5000; vec_fmt[2] = 3'd4;
        vec_instr[3] = 32'h001000EF; vec_imm[3] = 64'h0000_0000_0000_0800; vec_fmt[3] = 3'd5;

        // Reset
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("rst_out_valid", 64'(a_out_valid), 64'd0);
        check("rst_in_ready",  64'(a_in_ready),  64'd1);
        check("rst_out_imm",   a_out_imm,        64'd0);
        check("rst_out_fmt",   64'(a_out_fmt),   64'd0);
        check("rst_out_tag",   64'(a_out_tag),   64'd0);
        check("rst_cnt",       64'(a_cnt),       64'd0);
        check("rst32_valid",   64'(b_out_valid), 64'd0);

        // addi x1, x0, -1
        a_in_valid = 1'b1; a_in_instr = 32'hFFF00093; a_in_tag = 8'd1;
        step();
        check("addi_valid", 64'(a_out_valid), 64'd1);
        check("addi_imm",   a_out_imm,        64'hFFFF_FFFF_FFFF_FFFF);
        check("addi_fmt",   64'(a_out_fmt),   64'd1);
        check("addi_tag",   64'(a_out_tag),   64'd1);

        // Back-to-back S, B, U, J with out_ready held high
        for (int i = 0; i < 4; i++) begin
            a_in_instr = vec_instr[i];
            a_in_tag   = 8'(i + 2);
            step();
            check($sformatf("b2b%0d_valid", i), 64'(a_out_valid), 64'd1);
            check($sformatf("b2b%0d_imm", i),   a_out_imm,        vec_imm[i]);
            check($sformatf("b2b%0d_fmt", i),   64'(a_out_fmt),   64'(vec_fmt[i]));
            check($sformatf("b2b%0d_tag", i),   64'(a_out_tag),   64'(i + 2));
            check($sformatf("b2b%0d_rdy", i),   64'(a_in_ready),  64'd1);
        end
        a_in_valid = 1'b0;
        step();
        check("drain_valid", 64'(a_out_valid), 64'd0);

        // Backpressure: A=imm 5, B=imm 7, C=imm 9
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_instr = 32'h00500093; a_in_tag = 8'd10;
        step();
        check("bp_a_tag",   64'(a_out_tag),  64'd10);
        check("bp_a_rdy",   64'(a_in_ready), 64'd1);
        a_in_instr = 32'h00700093; a_in_tag = 8'd11;
        step();
        check("bp_b_rdy",   64'(a_in_ready), 64'd0);
        check("bp_b_imm",   a_out_imm,       64'd5);
        check("bp_b_tag",   64'(a_out_tag),  64'd10);
        a_in_instr = 32'h00900093; a_in_tag = 8'd12;
        step();
        check("bp_c_rdy",   64'(a_in_ready),  64'd0);
        check("bp_c_valid", 64'(a_out_valid), 64'd1);
        check("bp_c_imm",   a_out_imm,        64'd5);
        check("bp_c_tag",   64'(a_out_tag),   64'd10);
        a_out_ready = 1'b1;
        step();
        check("rel1_tag",   64'(a_out_tag),  64'd11);
        check("rel1_imm",   a_out_imm,       64'd7);
        check("rel1_rdy",   64'(a_in_ready), 64'd1);
        step();
        check("rel2_tag",   64'(a_out_tag),   64'd12);
        check("rel2_imm",   a_out_imm,        64'd9);
        check("rel2_valid", 64'(a_out_valid), 64'd1);
        a_in_valid = 1'b0;
        step();
        check("rel3_valid", 64'(a_out_valid), 64'd0);

        // Illegal opcodes
        a_in_valid = 1'b1; a_in_instr = 32'h0000007F; a_in_tag = 8'd20;
        step();
        check("ill_fmt", 64'(a_out_fmt), 64'd7);
        check("ill_imm", a_out_imm,      64'd0);
        check("ill_cnt1", 64'(a_cnt),    64'd1);
        step();
        step();
        check("ill_cnt3", 64'(a_cnt),    64'd3);
        a_cnt_clr = 1'b1;
        step();
        check("ill_clr", 64'(a_cnt),     64'd0);
        a_cnt_clr = 1'b0;
        a_in_valid = 1'b0;
        step();

        // Fill O and K with illegals, then present a third while in_ready is low
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_instr = 32'h0000007F; a_in_tag = 8'd30;
        step();
        a_in_tag = 8'd31;
        step();
        check("full_rdy",  64'(a_in_ready), 64'd0);
        check("full_cnt",  64'(a_cnt),      64'd2);
        a_in_tag = 8'd32;
        step();
        check("ign_cnt",   64'(a_cnt),      64'd2);
        check("ign_tag",   64'(a_out_tag),  64'd30);
        a_in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mrst_valid", 64'(a_out_valid), 64'd0);
        check("mrst_rdy",   64'(a_in_ready),  64'd1);
        check("mrst_cnt",   64'(a_cnt),       64'd0);
        a_out_ready = 1'b1;
        step();
        check("mrst_after", 64'(a_out_valid), 64'd0);

        // RV32 instance
        b_in_valid = 1'b1; b_in_instr = 32'h00301093; b_in_tag = 8'd40;
        step();
        check("rv32_slli_fmt", 64'(b_out_fmt), 64'd6);
        check("rv32_slli_imm", 64'(b_out_imm), 64'd3);
        check("rv32_slli_tag", 64'(b_out_tag), 64'd40);
        b_in_instr = 32'h0000003B;
        step();
        check("rv32_op32_fmt", 64'(b_out_fmt), 64'd7);
        check("rv32_op32_cnt", 64'(b_cnt),     64'd1);
        b_in_instr = 32'hFFF00093;
        step();
        check("rv32_addi_imm", 64'(b_out_imm), 64'hFFFF_FFFF);
        check("rv32_addi_fmt", 64'(b_out_fmt), 64'd1);
        b_in_instr = 32'h0000007F;
        step();
        check("rv32_cnt2", 64'(b_cnt), 64'd2);
        step();
        check("rv32_cnt3", 64'(b_cnt), 64'd3);
        step();
        step();
        check("rv32_sat", 64'(b_cnt), 64'd3);
        b_in_valid = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Pipelined, parametrised immediate generator for the decode stage. It accepts one 32-bit RV instruction per cycle over a valid/ready handshake and produces the XLEN-wide sign-extended immediate, a format code and a passthrough tag one cycle later. It covers all RV32I/RV64I immediate formats (I, S, B, U, J, shamt) and emits B/J immediates as true byte offsets. A 2-entry skid buffer provides full throughput under backpressure, and a saturating counter records illegal opcodes.

## Interface
- XLEN, 64: datapath width; legal values 32 or 64.
- TAG_W, 8: width of the passthrough tag (PC index / ROB id).
- CNT_W, 16: width of the illegal-opcode counter.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  instruction present.
- in_ready  out  1  block can accept; equals "skid entry empty".
- in_instr  in  32  instruction word.
- in_tag  in  TAG_W  carried unchanged to output.
- out_valid  out  1  output registers hold a result.
- out_ready  in  1  consumer accepts the result.
- out_imm  out  XLEN  immediate.
- out_fmt  out  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6=SHAMT, 7=ILLEGAL.
- out_tag  out  TAG_W  tag of the instruction.
- cnt_clr  in  1  synchronous clear of illegal_cnt.
- illegal_cnt  out  CNT_W  saturating count of accepted illegal instructions.

## Operation
- Decode on opcode = instr[6:0]; sign bit s = instr[31], extended to XLEN:
  - 0010011 OP-IMM: funct3 001/101 -> SHAMT, imm = zero-extended instr[25:20] (XLEN=64) or instr[24:20] (XLEN=32); otherwise I.
  - 0000011 LOAD, 1100111 JALR, 0011011 OP-IMM-32 (XLEN=64 only; ILLEGAL when XLEN=32; funct3 001/101 -> SHAMT from instr[24:20]) -> I: {s.., instr[31:20]}.
  - 0100011 -> S: {s.., instr[31:25], instr[11:7]}.
  - 1100011 -> B: {s.., instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}.
  - 0110111 LUI, 0010111 AUIPC -> U: {s.., instr[31:12], 12'b0}.
  - 1101111 -> J: {s.., instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}.
  - 0110011, 0111011 (0111011 ILLEGAL when XLEN=32) -> R, imm = 0.
  - Any other opcode -> ILLEGAL, imm = 0.
- Decode is combinational on the input side; the result is registered (1 stage).
- Skid buffer, two entries: output register (O) and skid register (K).
  - Accept = in_valid & in_ready.
  - Accept while O empty, or while O drains this cycle (out_ready) with K empty: result -> O.
  - Accept while O full and not draining: result -> K; in_ready drops next cycle.
  - O drains with K full: K -> O, K empties, in_ready rises next cycle.
  - O drains with nothing pending: out_valid -> 0.
- illegal_cnt: +1 per accepted ILLEGAL instruction (counted at accept, not at output); it holds at 2^CNT_W-1; cnt_clr has priority over a simultaneous increment (result 0).

## Timing
- Reset: out_valid=0, in_ready=1, out_imm=0, out_fmt=0, out_tag=0, K empty, illegal_cnt=0.
- Latency: accept in cycle N -> out_valid with that result in cycle N+1.
- Throughput: 1 instr/cycle while out_ready=1.
- in_ready depends only on registered state, with no combinational path from out_ready.
- Outputs hold stable while out_valid=1 and out_ready=0.
- Order is strictly preserved: O always holds the older entry, K the younger.
- rst mid-stream: in-flight O and K contents are discarded, with no output in the following cycle; the counter clears.
- in_valid while in_ready=0: ignored, not counted, no state change.

## Test plan
- XLEN=64, addi 0xFFF00093 -> one cycle later out_imm=0xFFFFFFFFFFFFFFFF, out_fmt=1.
- Back-to-back, out_ready=1: sw 0xFE112E23, beq 0xFE000CE3, lui 0x123450B7, jal 0x001000EF -> imm -4 (fmt 2), -8 (fmt 3), 0x0000000012345000 (fmt 4), 0x800 (fmt 5) on consecutive cycles.
- Backpressure: hold out_ready=0 and present 3 instrs -> in_ready falls after 2 accepts, out_imm stable. Release -> all 3 exit in order, tags intact, no loss or duplication.
- Illegal 0x0000007F accepted 3 times -> fmt 7, imm 0, illegal_cnt=3. Assert cnt_clr in the same cycle as a 4th illegal -> illegal_cnt=0. With CNT_W=2, 5 illegals -> saturates at 3.
- XLEN=32: slli 0x00301093 -> fmt 6, imm=3. Opcode 0111011 -> fmt 7. addi -1 -> 0xFFFFFFFF.
- Assert rst with O and K full -> next cycle out_valid=0, in_ready=1, illegal_cnt=0.
